// File: rtl/neuron_mac_seq_if.sv
// -----------------------------------------------------------------------------
// neuron_mac_seq_if
// Bundles the control and data signals between a layer controller and one
// sequential neuron.
//   En    : global clock enable (controller -> neuron)
//   Run   : start request (controller -> neuron)
//   Mode  : 0 = hard sigmoid, 1 = ReLU (controller -> neuron)
//   X, W  : packed inputs/weights, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   B     : bias
//   Y     : activation result (neuron -> controller)
//   Busy  : computation in progress (neuron -> controller)
//   Done  : one-enabled-cycle pulse when Y updates (neuron -> controller)
// Modports: master = controller side, slave = neuron side.
// -----------------------------------------------------------------------------
interface neuron_mac_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_INPUTS   = 4
);
    logic                           En;
    logic                           Run;
    logic                           Mode;
    logic [N_INPUTS*DATA_WIDTH-1:0] X;
    logic [N_INPUTS*DATA_WIDTH-1:0] W;
    logic [DATA_WIDTH-1:0]          B;
    logic [DATA_WIDTH-1:0]          Y;
    logic                           Busy;
    logic                           Done;

    modport master (output En, Run, Mode, X, W, B, input Y, Busy, Done);
    modport slave  (input En, Run, Mode, X, W, B, output Y, Busy, Done);
endinterface

// File: rtl/neuron_mac_seq.sv
// -----------------------------------------------------------------------------
// neuron_mac_seq
// Sequential fixed-point neuron: loads bias into the accumulator, performs one
// saturating multiply-accumulate per cycle over N_INPUTS (X, W) pairs, then
// applies a hard-sigmoid or ReLU activation and pulses Done.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : neuron_mac_seq_if.slave (En, Run, Mode, X, W, B in; Y, Busy, Done out)
// Configuration macro: NEURON_RELU_EN. When defined, Mode selects ReLU or
// sigmoid; when undefined, Mode is ignored and only the sigmoid is built.
// -----------------------------------------------------------------------------
module neuron_mac_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4,
    parameter int N_INPUTS   = 4,
    parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(N_INPUTS) + 2
) (
    input logic             clk,
    input logic             rst,
    neuron_mac_seq_if.slave bus
);
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int PW    = 2 * DATA_WIDTH;   // full product width
    localparam int SW    = ACC_WIDTH + 1;    // scaled product width

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

    // Saturation bounds expressed in the widened sum format.
    localparam logic signed [ACC_WIDTH+1:0] SUM_MAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH+1:0] SUM_MIN = {3'b111, {(ACC_WIDTH-1){1'b0}}};

    localparam logic signed [ACC_WIDTH:0] SIG_ONE  = (ACC_WIDTH+1)'(1 << FRAC_BITS);
    localparam logic signed [ACC_WIDTH:0] SIG_HALF = (ACC_WIDTH+1)'(1 << (FRAC_BITS - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_ACT  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [DATA_WIDTH-1:0]         y_q, y_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          capture;

    logic signed [DATA_WIDTH-1:0]  xr_q [N_INPUTS];
    logic signed [DATA_WIDTH-1:0]  wr_q [N_INPUTS];

    // ---------------- MAC datapath ----------------
    logic signed [PW-1:0]          prod, prod_shr;
    logic signed [PW+SW-1:0]       prod_ext;
    logic signed [SW-1:0]          prod_s;
    logic signed [ACC_WIDTH+1:0]   sum;
    logic signed [ACC_WIDTH-1:0]   acc_sat;

    assign prod     = xr_q[idx_q] * wr_q[idx_q];
    assign prod_shr = prod >>> FRAC_BITS;
    // Sign-extend wide enough, then keep SW bits: covers both extension and
    // truncation without depending on which of PW/SW is larger.
    assign prod_ext = {{SW{prod_shr[PW-1]}}, prod_shr};
    assign prod_s   = prod_ext[SW-1:0];
    assign sum      = {{2{acc_q[ACC_WIDTH-1]}}, acc_q} + {prod_s[SW-1], prod_s};

    always_comb begin
        if (sum > SUM_MAX)      acc_sat = SUM_MAX[ACC_WIDTH-1:0];
        else if (sum < SUM_MIN) acc_sat = SUM_MIN[ACC_WIDTH-1:0];
        else                    acc_sat = sum[ACC_WIDTH-1:0];
    end

    // ---------------- Activation datapath ----------------
    logic signed [ACC_WIDTH-1:0]   acc_shr;
    logic signed [ACC_WIDTH:0]     sig_s;
    logic [DATA_WIDTH-1:0]         sig_y, act_y;

    assign acc_shr = acc_q >>> 2;
    assign sig_s   = {acc_shr[ACC_WIDTH-1], acc_shr} + SIG_HALF;

    always_comb begin
        if (sig_s < 0)            sig_y = '0;
        else if (sig_s > SIG_ONE) sig_y = SIG_ONE[DATA_WIDTH-1:0];
        else                      sig_y = sig_s[DATA_WIDTH-1:0];
    end

`ifdef NEURON_RELU_EN
    localparam logic signed [ACC_WIDTH-1:0] RELU_MAX = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);

    logic                  mode_q;
    logic [DATA_WIDTH-1:0] relu_y;

    always_comb begin
        if (acc_q[ACC_WIDTH-1])    relu_y = '0;
        else if (acc_q > RELU_MAX) relu_y = RELU_MAX[DATA_WIDTH-1:0];
        else                       relu_y = acc_q[DATA_WIDTH-1:0];
    end

    assign act_y = mode_q ? relu_y : sig_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  mode_q <= 1'b0;
        else if (bus.En && capture) mode_q <= bus.Mode;
    end
`else
    logic unused_mode;
    assign unused_mode = bus.Mode;
    assign act_y       = sig_y;
`endif

    // ---------------- Control FSM ----------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Run) begin
                    capture = 1'b1;
                    acc_d   = {{(ACC_WIDTH-DATA_WIDTH){bus.B[DATA_WIDTH-1]}}, bus.B};
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_sat;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_d = S_ACT;
            end
            S_ACT: begin
                y_d     = act_y;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                // Unreachable encoding: recover cleanly to IDLE.
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.En) begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the operand arrays are left out of reset; they are always written
    // at acceptance before being read, so reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (bus.En && capture) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                xr_q[i] <= bus.X[i*DATA_WIDTH +: DATA_WIDTH];
                wr_q[i] <= bus.W[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.Y    = y_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac_seq
// Self-checking bench for neuron_mac_seq (DATA_WIDTH=8, FRAC_BITS=4,
// N_INPUTS=2). Expected Y values come from a behavioural model and are queued
// at Run time, then popped when Done is observed.
// -----------------------------------------------------------------------------
module tb_neuron_mac_seq;
    localparam int DW  = 8;
    localparam int FB  = 4;
    localparam int N   = 2;
    localparam int LAT = N + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    neuron_mac_seq_if #(.DATA_WIDTH(DW), .N_INPUTS(N)) bus ();

    neuron_mac_seq #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .N_INPUTS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_q[$];

    // Behavioural reference: floor-scaled products, saturation after every
    // addition to an 11-bit accumulator, then the selected activation.
    function automatic int model_y(input logic signed [7:0] x0, x1, w0, w1, b,
                                   input logic mode);
        int acc;
        int p;
        logic use_relu;
        acc = int'(b);
        for (int i = 0; i < 2; i++) begin
            p   = (i == 0) ? (int'(x0) * int'(w0)) >>> FB : (int'(x1) * int'(w1)) >>> FB;
            acc = acc + p;
            if (acc > 1023)  acc = 1023;
            if (acc < -1024) acc = -1024;
        end
`ifdef NEURON_RELU_EN
        use_relu = mode;
`else
        use_relu = mode & 1'b0;
`endif
        if (use_relu) begin
            if (acc < 0)   return 0;
            if (acc > 127) return 127;
            return acc;
        end
        p = (acc >>> 2) + 8;
        if (p < 0)  return 0;
        if (p > 16) return 16;
        return p;
    endfunction

    // Called on a negedge with the DUT idle; returns on the negedge after the
    // accepting edge with Run released.
    task automatic start(input logic [7:0] x0, x1, w0, w1, b, input logic mode);
        bus.X    = {x1, x0};
        bus.W    = {w1, w0};
        bus.B    = b;
        bus.Mode = mode;
        bus.Run  = 1'b1;
        exp_q.push_back(model_y(x0, x1, w0, w1, b, mode));
        @(negedge clk);
        bus.Run = 1'b0;
    endtask

    // Advances negedge by negedge until Done is seen or the budget runs out.
    task automatic wait_done(input int budget, output int cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.Done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic scoreboard_pop(input string name, input int exp_lat);
        int  cycles;
        bit  to;
        int  exp;
        wait_done(40, cycles, to);
        exp = exp_q.pop_front();
        n_cmp++;
        if (to) begin
            n_mis++;
            $display("FAIL %s: Done not seen within 40 cycles", name);
        end else begin
            n_cmp++;
            if (int'($signed(bus.Y)) !== exp) begin
                n_mis++;
                $display("FAIL %s Y: got %0d expected %0d", name, $signed(bus.Y), exp);
            end
            n_cmp++;
            if (cycles !== exp_lat) begin
                n_mis++;
                $display("FAIL %s latency: got %0d expected %0d", name, cycles, exp_lat);
            end
            n_cmp++;
            if (bus.Busy !== 1'b0) begin
                n_mis++;
                $display("FAIL %s Busy at Done: got %b expected 0", name, bus.Busy);
            end
        end
    endtask

    task automatic count_done(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) hits++;
        end
    endtask

    task automatic test_reset();
        bus.En = 1'b1; bus.Run = 1'b1; bus.Mode = 1'b0;
        bus.X = {8'd16, 8'd16}; bus.W = {8'd16, 8'd16}; bus.B = 8'd16;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({bus.Y, bus.Busy, bus.Done} !== 10'b0) begin
            n_mis++;
            $display("FAIL reset outputs: got Y=%0d Busy=%b Done=%b expected 0/0/0",
                     bus.Y, bus.Busy, bus.Done);
        end
        bus.Run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start(8'd16, 8'd0, 8'd78, -8'sd89, -8'sd38, 1'b0);
        n_cmp++;
        if (bus.Busy !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_release Busy: got %b expected 1", bus.Busy);
        end
        scoreboard_pop("reset_release", LAT);
    endtask

    task automatic test_xor();
        for (int m = 0; m < 2; m++) begin
            start(8'd16, 8'd16, 8'd78, -8'sd89, -8'sd38, m[0]);
            scoreboard_pop("xor_16_16", LAT);
            start(8'd16, 8'd0,  8'd78, -8'sd89, -8'sd38, m[0]);
            scoreboard_pop("xor_16_0", LAT);
            start(8'd0,  8'd0,  8'd78, -8'sd89, -8'sd38, m[0]);
            scoreboard_pop("xor_0_0", LAT);
        end
    endtask

    task automatic test_saturation();
        start(8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 1'b1);
        scoreboard_pop("sat_mode1", LAT);
        start(8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 1'b0);
        scoreboard_pop("sat_mode0", LAT);
        start(-8'sd128, 8'd127, 8'd127, 8'd127, -8'sd128, 1'b1);
        scoreboard_pop("sat_negative", LAT);
    endtask

    task automatic test_stall();
        logic [7:0] y_hold;
        start(8'd16, 8'd0, 8'd78, -8'sd89, -8'sd38, 1'b1);
        bus.En = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
            n_mis++;
            $display("FAIL stall_mid_mac: got Busy=%b Done=%b expected 1/0", bus.Busy, bus.Done);
        end
        bus.En = 1'b1;
        // Three stalled cycles already elapsed; the remaining latency is unchanged.
        scoreboard_pop("stall_mid_mac", LAT);
        y_hold = bus.Y;
        bus.En = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.Done !== 1'b1 || bus.Y !== y_hold) begin
            n_mis++;
            $display("FAIL done_hold_stall: got Done=%b Y=%0d expected 1/%0d", bus.Done, bus.Y, y_hold);
        end
        bus.En = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.Done !== 1'b0) begin
            n_mis++;
            $display("FAIL done_clear: got %b expected 0", bus.Done);
        end
    endtask

    task automatic test_ignore_run();
        int hits;
        start(8'd16, 8'd0, 8'd78, -8'sd89, -8'sd38, 1'b0);
        // Retrigger while busy with different operands: must be ignored, and
        // the captured operands must be the ones used.
        bus.X = {8'd0, 8'd0}; bus.W = {8'd0, 8'd0}; bus.B = 8'd100; bus.Mode = 1'b1;
        bus.Run = 1'b1;
        @(negedge clk);
        bus.Run = 1'b0;
        scoreboard_pop("run_while_busy", LAT - 1);
        count_done(6, hits);
        n_cmp++;
        if (hits !== 0) begin
            n_mis++;
            $display("FAIL no_second_done: got %0d extra Done cycles expected 0", hits);
        end
    endtask

    task automatic test_reset_midop();
        int hits;
        start(8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 1'b1);
        void'(exp_q.pop_back());
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Y !== 8'd0) begin
            n_mis++;
            $display("FAIL reset_midop: got Busy=%b Done=%b Y=%0d expected 0/0/0",
                     bus.Busy, bus.Done, bus.Y);
        end
        rst = 1'b1;
        count_done(6, hits);
        n_cmp++;
        if (hits !== 0) begin
            n_mis++;
            $display("FAIL reset_midop_done: got %0d Done cycles expected 0", hits);
        end
        start(8'd16, 8'd0, 8'd78, -8'sd89, -8'sd38, 1'b0);
        scoreboard_pop("after_reset_midop", LAT);
    endtask

    task automatic test_back_to_back();
        logic [7:0] v [5];
        int         cycles;
        bit         to;
        int         exp;
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 5; j++) v[j] = 8'($urandom_range(0, 255));
            bus.X = {v[1], v[0]}; bus.W = {v[3], v[2]}; bus.B = v[4];
            bus.Mode = 1'($urandom_range(0, 1));
            bus.Run  = 1'b1;
            exp_q.push_back(model_y(v[0], v[1], v[2], v[3], v[4], bus.Mode));
            wait_done(40, cycles, to);
            if (k == 5) bus.Run = 1'b0;
            exp = exp_q.pop_front();
            n_cmp++;
            if (to) begin
                n_mis++;
                $display("FAIL b2b_%0d: Done not seen within 40 cycles", k);
                bus.Run = 1'b0;
                break;
            end
            n_cmp++;
            if (int'($signed(bus.Y)) !== exp) begin
                n_mis++;
                $display("FAIL b2b_%0d Y: got %0d expected %0d", k, $signed(bus.Y), exp);
            end
            n_cmp++;
            if (cycles !== N + 2) begin
                n_mis++;
                $display("FAIL b2b_%0d period: got %0d expected %0d", k, cycles, N + 2);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bus.En = 1'b1; bus.Run = 1'b0; bus.Mode = 1'b0;
        bus.X = '0; bus.W = '0; bus.B = '0;
        test_reset();
        test_xor();
        test_saturation();
        test_stall();
        test_ignore_run();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Parametrised sequential neuron: N_INPUTS signed fixed-point inputs, runtime-loaded weights and bias, one multiply-accumulate per cycle, then a selectable activation (hard sigmoid or ReLU). It is the generic successor to the fixed-weight, two-input neurons in the XOR network. Layers are built by instantiating it per neuron and sharing a controller that drives Run and collects Done.

## Interface
- DATA_WIDTH, 8: width of X, W, B and Y elements, two's complement.
- FRAC_BITS, 4: fractional bits of the Q format, so ONE = 2^FRAC_BITS.
- N_INPUTS, 4: number of inputs and weights, ≥1.
- ACC_WIDTH, DATA_WIDTH+$clog2(N_INPUTS)+2: accumulator width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- En  in  1  global clock enable; 0 freezes every register.
- Run  in  1  start request, sampled in IDLE.
- Mode  in  1  0 = hard sigmoid, 1 = ReLU.
- X  in  N_INPUTS*DATA_WIDTH  packed inputs; element i is X[i*DATA_WIDTH +: DATA_WIDTH].
- W  in  N_INPUTS*DATA_WIDTH  packed weights, same packing as X.
- B  in  DATA_WIDTH  bias.
- Y  out  DATA_WIDTH  activation result, held until the next result.
- Busy  out  1  high from the accepted Run until Done.
- Done  out  1  one-enabled-cycle pulse when Y updates.

## Operation
- States: IDLE, MAC, ACT.
- All state, data and output registers update only on a rising edge with En=1.
- **IDLE**:
  - Run=1 captures X, W and Mode into registers.
  - ACC is loaded with B, sign-extended to ACC_WIDTH.
  - idx is set to 0, Busy to 1, and the state moves to MAC.
- **MAC**:
  - The product P = XR[idx]*WR[idx] is 2*DATA_WIDTH signed.
  - P is arithmetic-shifted right by FRAC_BITS (floor), then sign-extended or truncated to ACC_WIDTH+1.
  - ACC ← saturate(ACC + P') to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - idx increments. When idx == N_INPUTS-1, the state moves to ACT.
- **ACT**:
  - Sigmoid: y = (ACC >>> 2) + ONE/2, clamped to [0, ONE].
  - ReLU: y = max(ACC, 0), clamped to 2^(DATA_WIDTH-1)-1.
  - Y ← y, Done ← 1, Busy ← 0, and the state returns to IDLE.
- Done clears on the next enabled edge.
- Run is ignored while Busy=1 or En=0. X, W, B and Mode may change freely after acceptance.
- State encoding is unused-safe: any illegal state returns to IDLE.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, Y=0, Busy=0, Done=0, ACC=0, idx=0.
- Reset mid-operation aborts the computation. No Done is produced and Y reads 0.
- Latency: Run accepted at edge k. Y and Done are valid after edge k+N_INPUTS+1. Busy is high for N_INPUTS+1 cycles.
- Back-to-back: Run may be held high. The next acceptance occurs at the edge after Done, giving throughput of one result per N_INPUTS+2 cycles.
- En=0 inserts stall cycles anywhere. Outputs hold, including a pending Done pulse.
- Saturation is applied after every addition, not only at the end.

## Configuration
- NEURON_RELU_EN:
  - Defined: Mode selects ReLU or sigmoid as described.
  - Undefined: the Mode port remains but is ignored, the ReLU datapath is not synthesised, and ACT always computes the hard sigmoid.

## Test plan
All cases use DATA_WIDTH=8, FRAC_BITS=4, N_INPUTS=2 unless stated.
- Reset: hold rst=0 with Run=1 → Y=0, Busy=0, Done=0. Release, Run pulse → Busy=1 next cycle, Done exactly 3 cycles after acceptance.
- XOR-style vector:
  - Setup: W=(78,-89), B=-38.
  - X=(16,16) → ACC=-49, sigmoid Y=0. Same vector with Mode=1 → Y=0.
  - X=(16,0) → ACC=40, sigmoid Y=16; with Mode=1 → Y=40.
  - X=(0,0) → Y=0.
- Saturation: X=(127,127), W=(127,127), B=127 → ACC saturates at 1023; Mode=1 → Y=127; Mode=0 → Y=16.
- Stall and ignore:
  - Drop En for 3 cycles mid-MAC → result unchanged, latency +3.
  - Pulse Run while Busy → no second Done.
  - Done held high while En=0.
- Reset mid-op: assert rst one cycle after acceptance → Busy=0, no Done. A subsequent Run with X=(16,0) yields the correct Y=16.
- Macro off (NEURON_RELU_EN undefined): Mode=1, X=(16,0) → Y=16 (sigmoid path).
